// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - registered opcode decode and multi-cycle sequencing FSM
module seq_control_unit #(
   parameter int OPCODE_WIDTH = 8,
   parameter int MUL_LATENCY  = 2
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    INSTR_VALID,
   input  logic [OPCODE_WIDTH-1:0] OPCODE,
   input  logic                    BUSYWAIT,
   output logic [2:0]              ALUOP,
   output logic                    SIGN_CONTROL,
   output logic                    OPERAND_CONTROL,
   output logic [1:0]              BRANCH_CONTROL,
   output logic                    JUMP_CONTROL,
   output logic                    WRITE_ENABLE,
   output logic                    READ_DATA_MEM,
   output logic                    WRITE_DATA_MEM,
   output logic                    PC_STALL,
   output logic                    INSTR_DONE,
   output logic                    ILLEGAL_OP
);

   typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

   localparam logic [7:0] OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03;
   localparam logic [7:0] OP_AND = 8'h04, OP_OR = 8'h05, OP_J = 8'h06, OP_BEQ = 8'h07;
   localparam logic [7:0] OP_LWD = 8'h08, OP_LWI = 8'h09, OP_SWD = 8'h0A, OP_SWI = 8'h0B;
   localparam logic [7:0] OP_MUL = 8'h0C, OP_SHIFT = 8'h0D, OP_BNE = 8'h0E;

   // MUL occupies EXEC for MUL_LATENCY cycles: load N-1 and leave EXEC when it hits zero
   localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

   state_t                  state, state_nxt;
   logic [OPCODE_WIDTH-1:0] opcode_q;
   logic [3:0]              mul_cnt;
   logic                    accept;
   logic                    legal_in, legal_q;
   logic [7:0]              op_in, op_q;
   logic [2:0]              dec_aluop;
   logic                    dec_sign, dec_operand;

   assign accept   = (state == IDLE) && INSTR_VALID;
   assign op_in    = OPCODE[7:0];
   assign op_q     = opcode_q[7:0];
   // Any bit above the low byte makes the opcode illegal regardless of the low byte
   assign legal_in = ((OPCODE >> 8) == '0) && (op_in <= OP_BNE);
   assign legal_q  = ((opcode_q >> 8) == '0) && (op_q <= OP_BNE);

   // Decode the incoming opcode into the values registered at accept
   always_comb begin
      dec_aluop   = 3'b000;
      dec_sign    = 1'b0;
      dec_operand = 1'b0;
      if (legal_in) begin
         case (op_in)
            OP_ADD:   dec_aluop = 3'b001;
            OP_SUB:   begin dec_aluop = 3'b001; dec_sign = 1'b1; end
            OP_AND:   dec_aluop = 3'b010;
            OP_OR:    dec_aluop = 3'b011;
            OP_MUL:   dec_aluop = 3'b100;
            OP_SHIFT: begin dec_aluop = 3'b101; dec_operand = 1'b1; end
            OP_LOADI, OP_LWI, OP_SWI: dec_operand = 1'b1;
            OP_BEQ, OP_BNE: dec_sign = 1'b1;
            default: ;
         endcase
      end
   end

   // Latch opcode and datapath selects on accept; held until the next accept
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         opcode_q        <= '0;
         ALUOP           <= 3'b000;
         SIGN_CONTROL    <= 1'b0;
         OPERAND_CONTROL <= 1'b0;
      end else if (accept) begin
         opcode_q        <= OPCODE;
         ALUOP           <= dec_aluop;
         SIGN_CONTROL    <= dec_sign;
         OPERAND_CONTROL <= dec_operand;
      end
   end

   // Multiply latency down-counter; reloaded on every accept, counts while in EXEC
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         mul_cnt <= 4'd0;
      else if (accept)
         mul_cnt <= MUL_INIT;
      else if (state == EXEC && mul_cnt != 4'd0)
         mul_cnt <= mul_cnt - 4'd1;
   end

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and strobe decode from state and latched opcode
   always_comb begin
      state_nxt      = state;
      BRANCH_CONTROL = 2'b00;
      JUMP_CONTROL   = 1'b0;
      WRITE_ENABLE   = 1'b0;
      READ_DATA_MEM  = 1'b0;
      WRITE_DATA_MEM = 1'b0;
      INSTR_DONE     = 1'b0;
      ILLEGAL_OP     = 1'b0;
      case (state)
         IDLE: if (INSTR_VALID) state_nxt = EXEC;
         EXEC: begin
            if (!legal_q) begin
               ILLEGAL_OP = 1'b1;
               INSTR_DONE = 1'b1;
               state_nxt  = IDLE;
            end else begin
               case (op_q)
                  OP_MUL: if (mul_cnt == 4'd0) state_nxt = WB;
                  OP_J:   begin JUMP_CONTROL = 1'b1; INSTR_DONE = 1'b1; state_nxt = IDLE; end
                  OP_BEQ: begin BRANCH_CONTROL = 2'b01; INSTR_DONE = 1'b1; state_nxt = IDLE; end
                  OP_BNE: begin BRANCH_CONTROL = 2'b10; INSTR_DONE = 1'b1; state_nxt = IDLE; end
                  OP_LWD, OP_LWI, OP_SWD, OP_SWI: state_nxt = MEM;
                  default: state_nxt = WB;
               endcase
            end
         end
         MEM: begin
            if (op_q == OP_LWD || op_q == OP_LWI) begin
               READ_DATA_MEM = 1'b1;
               if (!BUSYWAIT) state_nxt = WB;
            end else begin
               WRITE_DATA_MEM = 1'b1;
               if (!BUSYWAIT) begin
                  INSTR_DONE = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end
         WB: begin
            WRITE_ENABLE = 1'b1;
            INSTR_DONE   = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign PC_STALL = (state != IDLE) && !INSTR_DONE;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - directed self-checking bench for seq_control_unit
module tb_seq_control_unit;

   logic       CLK, RESET, INSTR_VALID, BUSYWAIT;
   logic [8:0] OPCODE;
   logic [2:0] ALUOP;
   logic       SIGN_CONTROL, OPERAND_CONTROL, JUMP_CONTROL, WRITE_ENABLE;
   logic       READ_DATA_MEM, WRITE_DATA_MEM, PC_STALL, INSTR_DONE, ILLEGAL_OP;
   logic [1:0] BRANCH_CONTROL;
   logic [8:0] strobes;
   logic [8:0] exp_s;
   int         checks = 0;
   int         errors = 0;

   seq_control_unit #(.OPCODE_WIDTH(9), .MUL_LATENCY(3)) dut (
      .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE),
      .BUSYWAIT(BUSYWAIT), .ALUOP(ALUOP), .SIGN_CONTROL(SIGN_CONTROL),
      .OPERAND_CONTROL(OPERAND_CONTROL), .BRANCH_CONTROL(BRANCH_CONTROL),
      .JUMP_CONTROL(JUMP_CONTROL), .WRITE_ENABLE(WRITE_ENABLE),
      .READ_DATA_MEM(READ_DATA_MEM), .WRITE_DATA_MEM(WRITE_DATA_MEM),
      .PC_STALL(PC_STALL), .INSTR_DONE(INSTR_DONE), .ILLEGAL_OP(ILLEGAL_OP)
   );

   // {BRANCH[1:0], JUMP, WE, RD, WR, PC_STALL, DONE, ILLEGAL}
   assign strobes = {BRANCH_CONTROL, JUMP_CONTROL, WRITE_ENABLE, READ_DATA_MEM,
                     WRITE_DATA_MEM, PC_STALL, INSTR_DONE, ILLEGAL_OP};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Present an opcode for one edge; returns 1 ns into cycle 1 after accept
   task automatic run_accept(input logic [8:0] op);
      OPCODE      = op;
      INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL reset_strobes got=%h exp=%h", strobes, 9'h000); end
      checks++; if (ALUOP !== 3'b000) begin errors++; $display("FAIL reset_aluop got=%b exp=000", ALUOP); end
      checks++; if ({SIGN_CONTROL, OPERAND_CONTROL} !== 2'b00) begin errors++; $display("FAIL reset_sign_operand got=%b exp=00", {SIGN_CONTROL, OPERAND_CONTROL}); end
      OPCODE = 9'h002; INSTR_VALID = 1'b1;
      step(); step();
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL reset_held_strobes got=%h exp=%h", strobes, 9'h000); end
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic test_add();
      run_accept(9'h002);
      BUSYWAIT = 1'b1;
      checks++; if (strobes !== 9'h004) begin errors++; $display("FAIL add_c1_strobes got=%h exp=%h", strobes, 9'h004); end
      checks++; if (ALUOP !== 3'b001) begin errors++; $display("FAIL add_c1_aluop got=%b exp=001", ALUOP); end
      checks++; if (SIGN_CONTROL !== 1'b0) begin errors++; $display("FAIL add_c1_sign got=%b exp=0", SIGN_CONTROL); end
      OPCODE = 9'h00C; INSTR_VALID = 1'b1;
      step();
      INSTR_VALID = 1'b0; BUSYWAIT = 1'b0;
      checks++; if (strobes !== 9'h022) begin errors++; $display("FAIL add_c2_strobes got=%h exp=%h", strobes, 9'h022); end
      checks++; if (ALUOP !== 3'b001) begin errors++; $display("FAIL add_c2_aluop got=%b exp=001", ALUOP); end
      step();
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL add_c3_strobes got=%h exp=%h", strobes, 9'h000); end
   endtask

   task automatic test_mul();
      run_accept(9'h00C);
      for (int c = 1; c <= 5; c++) begin
         exp_s = (c <= 3) ? 9'h004 : (c == 4) ? 9'h022 : 9'h000;
         checks++; if (strobes !== exp_s) begin errors++; $display("FAIL mul_c%0d_strobes got=%h exp=%h", c, strobes, exp_s); end
         if (c <= 3) begin
            checks++; if (ALUOP !== 3'b100) begin errors++; $display("FAIL mul_c%0d_aluop got=%b exp=100", c, ALUOP); end
         end
         step();
      end
   endtask

   task automatic test_load_lwi();
      int rd_cycles;
      rd_cycles = 0;
      run_accept(9'h009);
      BUSYWAIT = 1'b1;
      checks++; if ({ALUOP, OPERAND_CONTROL} !== 4'b0001) begin errors++; $display("FAIL lwi_aluop_operand got=%b exp=0001", {ALUOP, OPERAND_CONTROL}); end
      for (int c = 1; c <= 8; c++) begin
         if (c == 6) BUSYWAIT = 1'b0;
         exp_s = (c == 1) ? 9'h004 : (c <= 6) ? 9'h014 : (c == 7) ? 9'h022 : 9'h000;
         checks++; if (strobes !== exp_s) begin errors++; $display("FAIL lwi_c%0d_strobes got=%h exp=%h", c, strobes, exp_s); end
         if (READ_DATA_MEM === 1'b1) rd_cycles++;
         step();
      end
      checks++; if (rd_cycles !== 5) begin errors++; $display("FAIL lwi_read_cycles got=%0d exp=5", rd_cycles); end
   endtask

   task automatic test_store_swd();
      run_accept(9'h00A);
      BUSYWAIT = 1'b0;
      checks++; if (strobes !== 9'h004) begin errors++; $display("FAIL swd_c1_strobes got=%h exp=%h", strobes, 9'h004); end
      checks++; if (OPERAND_CONTROL !== 1'b0) begin errors++; $display("FAIL swd_operand got=%b exp=0", OPERAND_CONTROL); end
      step();
      checks++; if (strobes !== 9'h00A) begin errors++; $display("FAIL swd_c2_strobes got=%h exp=%h", strobes, 9'h00A); end
      step();
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL swd_c3_strobes got=%h exp=%h", strobes, 9'h000); end
   endtask

   task automatic test_branch_jump();
      logic [8:0] ops [3];
      logic [8:0] exps [3];
      logic       signs [3];
      ops = '{9'h00E, 9'h007, 9'h006};
      exps = '{9'h102, 9'h082, 9'h042};
      signs = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         run_accept(ops[i]);
         checks++; if (strobes !== exps[i]) begin errors++; $display("FAIL br_%h_strobes got=%h exp=%h", ops[i], strobes, exps[i]); end
         checks++; if (SIGN_CONTROL !== signs[i]) begin errors++; $display("FAIL br_%h_sign got=%b exp=%b", ops[i], SIGN_CONTROL, signs[i]); end
         step();
         checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL br_%h_after got=%h exp=%h", ops[i], strobes, 9'h000); end
      end
   endtask

   task automatic test_illegal();
      logic [8:0] ill [3];
      ill = '{9'h00F, 9'h0FF, 9'h102};
      for (int i = 0; i < 3; i++) begin
         run_accept(9'h005);
         checks++; if ({ALUOP, strobes} !== {3'b011, 9'h004}) begin errors++; $display("FAIL or_before_%h got=%b/%h exp=011/004", ill[i], ALUOP, strobes); end
         step(); step();
         run_accept(ill[i]);
         checks++; if (strobes !== 9'h003) begin errors++; $display("FAIL ill_%h_strobes got=%h exp=%h", ill[i], strobes, 9'h003); end
         checks++; if ({ALUOP, SIGN_CONTROL, OPERAND_CONTROL} !== 5'b00000) begin errors++; $display("FAIL ill_%h_decode got=%b exp=00000", ill[i], {ALUOP, SIGN_CONTROL, OPERAND_CONTROL}); end
         step();
         checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL ill_%h_after got=%h exp=%h", ill[i], strobes, 9'h000); end
      end
   endtask

   task automatic test_reset_mid_mem();
      run_accept(9'h00B);
      BUSYWAIT = 1'b1;
      step(); step();
      checks++; if ({strobes, OPERAND_CONTROL} !== {9'h00C, 1'b1}) begin errors++; $display("FAIL swi_mem2 got=%h/%b exp=00c/1", strobes, OPERAND_CONTROL); end
      #2 RESET = 1'b1;
      #1;
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL swi_async_reset_strobes got=%h exp=%h", strobes, 9'h000); end
      checks++; if ({ALUOP, OPERAND_CONTROL} !== 4'b0000) begin errors++; $display("FAIL swi_async_reset_decode got=%b exp=0000", {ALUOP, OPERAND_CONTROL}); end
      #1 RESET = 1'b0;
      BUSYWAIT = 1'b0;
      run_accept(9'h002);
      checks++; if ({ALUOP, strobes} !== {3'b001, 9'h004}) begin errors++; $display("FAIL post_reset_add_c1 got=%b/%h exp=001/004", ALUOP, strobes); end
      step();
      checks++; if (strobes !== 9'h022) begin errors++; $display("FAIL post_reset_add_c2 got=%h exp=%h", strobes, 9'h022); end
      step();
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL post_reset_add_c3 got=%h exp=%h", strobes, 9'h000); end
   endtask

   task automatic test_back_to_back();
      run_accept(9'h003);
      checks++; if ({ALUOP, SIGN_CONTROL, strobes} !== {3'b001, 1'b1, 9'h004}) begin errors++; $display("FAIL b2b_sub_c1 got=%b/%b/%h exp=001/1/004", ALUOP, SIGN_CONTROL, strobes); end
      OPCODE = 9'h006; INSTR_VALID = 1'b1;
      step();
      checks++; if (strobes !== 9'h022) begin errors++; $display("FAIL b2b_c2 got=%h exp=%h", strobes, 9'h022); end
      step();
      checks++; if ({ALUOP, strobes} !== {3'b001, 9'h000}) begin errors++; $display("FAIL b2b_c3_idle got=%b/%h exp=001/000", ALUOP, strobes); end
      step();
      INSTR_VALID = 1'b0;
      checks++; if ({ALUOP, strobes} !== {3'b000, 9'h042}) begin errors++; $display("FAIL b2b_c4_jump got=%b/%h exp=000/042", ALUOP, strobes); end
      step();
      checks++; if (strobes !== 9'h000) begin errors++; $display("FAIL b2b_c5 got=%h exp=%h", strobes, 9'h000); end
   endtask

   initial begin
      RESET = 1'b1; INSTR_VALID = 1'b0; OPCODE = 9'h000; BUSYWAIT = 1'b0;
      test_reset();
      test_add();
      test_mul();
      test_load_lwi();
      test_store_swd();
      test_branch_jump();
      test_illegal();
      test_reset_mid_mem();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Multi-cycle, parametrised instruction control unit for the Simple-Processor datapath. It replaces purely combinational opcode decode with a registered decode plus a sequencing FSM. The FSM stalls the PC for multi-cycle multiply and for data-cache accesses, and flags undefined opcodes instead of driving high-impedance. It sits between instruction fetch, which supplies `OPCODE`/`INSTR_VALID`, and the datapath/data cache, which consume the control strobes and return `BUSYWAIT`.

## Interface
Parameters:
- `OPCODE_WIDTH`, 8: opcode width. Bits above [7:0] must be zero, else the instruction is illegal.
- `MUL_LATENCY`, 2: EXEC cycles for MUL. Legal range 1..15.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `INSTR_VALID`  in  1  `OPCODE` is valid. Sampled only in IDLE.
- `OPCODE`  in  OPCODE_WIDTH  instruction opcode.
- `BUSYWAIT`  in  1  data cache busy. Sampled only in MEM.
- `ALUOP`  out  3  registered ALU select.
- `SIGN_CONTROL`  out  1  registered 2's-complement select.
- `OPERAND_CONTROL`  out  1  registered immediate select.
- `BRANCH_CONTROL`  out  2  strobe: 01=BEQ, 10=BNE, else 00.
- `JUMP_CONTROL`  out  1  strobe.
- `WRITE_ENABLE`  out  1  register-file write strobe.
- `READ_DATA_MEM`  out  1  cache read request.
- `WRITE_DATA_MEM`  out  1  cache write request.
- `PC_STALL`  out  1  hold PC.
- `INSTR_DONE`  out  1  final cycle of the instruction.
- `ILLEGAL_OP`  out  1  undefined opcode pulse.

## Operation
- **Opcode map:**
  - LOADI 0x00, MOV 0x01, ADD 0x02, SUB 0x03, AND 0x04, OR 0x05, J 0x06, BEQ 0x07.
  - LWD 0x08, LWI 0x09, SWD 0x0A, SWI 0x0B, MUL 0x0C, SHIFT 0x0D, BNE 0x0E.
- **Decode on accept:** IDLE with `INSTR_VALID`=1 latches the opcode and registers `ALUOP`, `SIGN_CONTROL` and `OPERAND_CONTROL`. These are held stable until the next accept.
- **ALUOP values:**
  - ADD/SUB → 001, AND → 010, OR → 011, MUL → 100, SHIFT → 101.
  - LOADI, MOV, loads and stores → 000.
  - Branch, jump and illegal → 000 (never Z).
- **SIGN_CONTROL** = 1 for SUB, BEQ and BNE.
- **OPERAND_CONTROL** = 1 for LOADI, SHIFT, LWI and SWI.
- **FSM states:** IDLE, EXEC, MEM, WB.
  - IDLE → EXEC on accept. `INSTR_VALID` is ignored in every other state.
  - EXEC, ALU ops (LOADI/MOV/ADD/SUB/AND/OR/SHIFT): 1 cycle, then WB.
  - EXEC, MUL: `MUL_LATENCY` cycles counted by an internal down-counter, then WB.
  - EXEC, J/BEQ/BNE: 1 cycle asserting `JUMP_CONTROL` or `BRANCH_CONTROL`, with `INSTR_DONE`=1, then IDLE.
  - EXEC, loads/stores: 1 cycle, then MEM.
  - EXEC, illegal: 1 cycle with `ILLEGAL_OP`=1 and `INSTR_DONE`=1, no other strobes, then IDLE.
  - MEM: `READ_DATA_MEM` (loads) or `WRITE_DATA_MEM` (stores) held high for every MEM cycle. On an edge with `BUSYWAIT`=0, loads go to WB and stores go to IDLE. With `BUSYWAIT`=1, stay in MEM.
  - WB: `WRITE_ENABLE`=1 and `INSTR_DONE`=1 for 1 cycle, then IDLE.
- **INSTR_DONE** is also 1 in MEM for a store when `BUSYWAIT`=0.
- **PC_STALL** = (state ≠ IDLE) AND NOT `INSTR_DONE`.
- All strobes are decoded from state and the latched opcode. They are never asserted in IDLE.

## Timing
- **Reset:**
  - Async reset forces IDLE and clears the latched opcode, MUL counter, `ALUOP`=000, `SIGN_CONTROL`=0 and `OPERAND_CONTROL`=0.
  - Every strobe, `PC_STALL`, `INSTR_DONE` and `ILLEGAL_OP` reads 0 immediately, including mid-MEM or mid-MUL.
  - The first accept can occur on the first rising edge after `RESET` falls.
- **Latency, accept edge to `INSTR_DONE` cycle:**
  - ALU ops: WB in the 2nd cycle after accept.
  - MUL: WB in cycle `MUL_LATENCY`+1.
  - Branch, jump and illegal: cycle 1.
  - Loads: WB in cycle 3 + (number of `BUSYWAIT`=1 MEM cycles).
  - Stores: cycle 2 + (number of `BUSYWAIT`=1 MEM cycles).
- **Throughput:** the next accept occurs no earlier than the edge after the `INSTR_DONE` cycle, because the FSM must return to IDLE.
- **Sampling rules:**
  - `BUSYWAIT` is sampled only at MEM edges; a `BUSYWAIT` pulse outside MEM has no effect.
  - An `OPCODE` change after accept has no effect until the next accept.
- **OPCODE_WIDTH** > 8 with any upper bit set is treated as illegal, even if the low byte matches a valid opcode.

## Test plan
- Reset, then ADD (0x02) accept: `ALUOP`=001 and `SIGN_CONTROL`=0 from cycle 1; `WRITE_ENABLE`=`INSTR_DONE`=1 in cycle 2 only; `PC_STALL`=1 in cycle 1 only.
- MUL with `MUL_LATENCY`=3: EXEC lasts 3 cycles with `ALUOP`=100 and `PC_STALL`=1; `WRITE_ENABLE` pulses in cycle 4.
- LWI (0x09) with `BUSYWAIT` high for 4 MEM cycles: `READ_DATA_MEM`=1 for 5 cycles, `OPERAND_CONTROL`=1, `WRITE_ENABLE` in cycle 7. SWD with `BUSYWAIT`=0: `WRITE_DATA_MEM`=1 for 1 cycle with `INSTR_DONE`=1 and `WRITE_ENABLE`=0.
- BNE (0x0E): `BRANCH_CONTROL`=10, `SIGN_CONTROL`=1 and `INSTR_DONE`=1 in cycle 1, no stall. J (0x06): `JUMP_CONTROL`=1 in cycle 1.
- Opcodes 0x0F, 0xFF, and 0x102 (with `OPCODE_WIDTH`=9): `ILLEGAL_OP`=1 for 1 cycle, `ALUOP`=000, no write or memory strobes.
- `RESET` asserted during the 2nd MEM cycle of SWI: `WRITE_DATA_MEM` and `PC_STALL` drop to 0 asynchronously; after release, an ADD completes normally.
